// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one ALU between two requesters.
// The granted op and operands are registered onto the ALU inputs. The ALU
// result is captured one cycle later and returned on a valid/ready response
// port tagged with the owning requester.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned RES_W  = 32,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned MAX_OP = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [RES_W-1:0]  alu_result,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [RES_W-1:0]  rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam logic [OP_W-1:0] MAX_OP_C = OP_W'(MAX_OP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic              rr_ptr;
  logic              cur_id;

  logic              grant_any;
  logic              grant_id;
  logic [OP_W-1:0]   grant_op;
  logic [DATA_W-1:0] grant_a;
  logic [DATA_W-1:0] grant_b;

  // Pick the requester to serve: a lone requester wins, contention follows rr_ptr.
  always_comb begin
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    grant_op   = grant_id ? req1_op : req0_op;
    grant_a    = grant_id ? req1_a  : req0_a;
    grant_b    = grant_id ? req1_b  : req0_b;
    req0_ready = (state == IDLE) && grant_any && !grant_id;
    req1_ready = (state == IDLE) && grant_any &&  grant_id;
  end

  // Arbitration FSM: accept in IDLE, capture the result in EXEC, hold it in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cur_id    <= 1'b0;
      alu_op    <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_op  <= grant_op;
            alu_in1 <= grant_a;
            alu_in2 <= grant_b;
            cur_id  <= grant_id;
            rr_ptr  <= ~grant_id;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          if (alu_op > MAX_OP_C) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            rsp_err  <= 1'b0;
            rsp_data <= alu_result;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed testbench for alu_share_arbiter; the ALU stub concatenates its operands.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [2:0]  req0_op, req1_op;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        req0_ready, req1_ready;
  logic [2:0]  alu_op;
  logic [15:0] alu_in1, alu_in2;
  logic [31:0] alu_result;
  logic        rsp_valid, rsp_id, rsp_err, rsp_ready;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign alu_result = {alu_in1, alu_in2};

  alu_share_arbiter #(.DATA_W(16), .RES_W(32), .OP_W(3), .MAX_OP(5)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .alu_op(alu_op), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_checks++; if (alu_op !== 3'd0) begin n_fail++; $display("FAIL reset_alu_op: got %h expected 0", alu_op); end
    n_checks++; if ({alu_in1, alu_in2} !== 32'h0) begin n_fail++; $display("FAIL reset_alu_in: got %h expected 0", {alu_in1, alu_in2}); end
    n_checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_flags: got %b expected 000", {rsp_valid, rsp_id, rsp_err}); end
    n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready_idle: got %b expected 00", {req0_ready, req1_ready}); end
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h900F; req0_b = 16'h0FFF;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    n_checks++; if ({alu_op, alu_in1, alu_in2} !== {3'd0, 16'h900F, 16'h0FFF}) begin n_fail++; $display("FAIL single_alu_in: got %h/%h/%h expected 0/900f/0fff", alu_op, alu_in1, alu_in2); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_rsp: got %b expected 0", rsp_valid); end
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_err} !== 3'b100) begin n_fail++; $display("FAIL single_rsp_flags: got %b expected 100", {rsp_valid, rsp_id, rsp_err}); end
    n_checks++; if (rsp_data !== 32'h900F0FFF) begin n_fail++; $display("FAIL single_rsp_data: got %h expected 900f0fff", rsp_data); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_handshake: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_contention();
    logic        id;
    logic [31:0] exp_data;
    reset = 1'b1; tick(); reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd1; req0_a = 16'h1010; req0_b = 16'h1100;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 16'hAAAA; req1_b = 16'h5555;
    #1;
    for (int i = 0; i < 4; i++) begin
      id = (i % 2) == 1;
      exp_data = id ? 32'hAAAA5555 : 32'h10101100;
      n_checks++; if ({req0_ready, req1_ready} !== {!id, id}) begin n_fail++; $display("FAIL contention_grant%0d: got %b expected %b", i, {req0_ready, req1_ready}, {!id, id}); end
      tick();
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL contention_exec_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); end
      tick();
      n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, id, exp_data}) begin n_fail++; $display("FAIL contention_rsp%0d: got %b/%b/%h expected 1/%b/%h", i, rsp_valid, rsp_id, rsp_data, id, exp_data); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    // rr_ptr is 0 after the alternating sequence; both still valid.
    req0_op = 3'd1; req0_a = 16'h1111; req0_b = 16'h2222;
    rsp_ready = 1'b0;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h11112222}) begin n_fail++; $display("FAIL bp_hold%0d: got %b/%b/%h expected 1/0/11112222", i, rsp_valid, rsp_id, rsp_data); end
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected 00", i, {req0_ready, req1_ready}); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    n_checks++; if ({rsp_valid, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake_cycle: got %b expected 10", {rsp_valid, req1_ready}); end
    tick();
    n_checks++; if ({rsp_valid, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_after_handshake: got %b expected 01", {rsp_valid, req1_ready}); end
    tick();
    req1_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'hAAAA5555}) begin n_fail++; $display("FAIL bp_next_rsp: got %b/%b/%h expected 1/1/aaaa5555", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_illegal_op();
    req1_valid = 1'b1; req1_op = 3'b110; req1_a = 16'h1234; req1_b = 16'h5678;
    #1;
    n_checks++; if (req1_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_grant: got %b expected 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    n_checks++; if (alu_op !== 3'b110) begin n_fail++; $display("FAIL illegal_alu_op: got %b expected 110", alu_op); end
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b111, 32'h0}) begin n_fail++; $display("FAIL illegal_rsp: got %b%b%b/%h expected 111/00000000", rsp_valid, rsp_id, rsp_err, rsp_data); end
    tick();
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 16'h0001; req1_b = 16'h0002;
    tick();
    req1_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b110, 32'h00010002}) begin n_fail++; $display("FAIL legal_after_illegal: got %b%b%b/%h expected 110/00010002", rsp_valid, rsp_id, rsp_err, rsp_data); end
    tick();
  endtask

  task automatic test_reset_midop();
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 16'hBEEF; req0_b = 16'hCAFE;
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++; if ({rsp_valid, rsp_data} !== 33'h0) begin n_fail++; $display("FAIL midreset_rsp: got %b/%h expected 0/00000000", rsp_valid, rsp_data); end
    n_checks++; if ({alu_op, alu_in1, alu_in2} !== 35'h0) begin n_fail++; $display("FAIL midreset_alu: got %h/%h/%h expected 0/0/0", alu_op, alu_in1, alu_in2); end
    req0_valid = 1'b1; req0_op = 3'd4; req0_a = 16'h0F0F; req0_b = 16'hF0F0;
    req1_valid = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_fail++; $display("FAIL midreset_first_grant: got %b expected 10", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h0F0FF0F0}) begin n_fail++; $display("FAIL midreset_rsp_after: got %b/%b/%h expected 1/0/0f0ff0f0", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  task automatic test_withdrawn();
    // rr_ptr is 1 after the previous grant to requester 0.
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h3333; req0_b = 16'h4444;
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h7777; req1_b = 16'h8888;
    #1;
    n_checks++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL withdrawn_ready: got %b expected 0", req1_ready); end
    tick();
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'h33334444}) begin n_fail++; $display("FAIL withdrawn_held_rsp: got %b/%b/%h expected 1/0/33334444", rsp_valid, rsp_id, rsp_data); end
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin n_fail++; $display("FAIL withdrawn_no_service%0d: got %b expected 000", i, {rsp_valid, req0_ready, req1_ready}); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_fail++; $display("FAIL withdrawn_rr_ptr: got %b expected 01", {req0_ready, req1_ready}); end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    n_checks++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 1'b1, 32'h77778888}) begin n_fail++; $display("FAIL withdrawn_final_rsp: got %b/%b/%h expected 1/1/77778888", rsp_valid, rsp_id, rsp_data); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_illegal_op();
    test_reset_midop();
    test_withdrawn();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
